// File: rtl/excp_commit.sv
// Exception / interrupt / ERET commit arbiter for a dual-issue pipeline.
// Picks at most one event per commit, reports it to CP0 with a one-cycle pulse,
// flushes the pipeline and redirects fetch, then locks out new events briefly.
module excp_commit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        l0_valid,
    input  logic        l1_valid,
    input  logic [31:0] l0_pc,
    input  logic [31:0] l1_pc,
    input  logic        l0_slot,
    input  logic        l1_slot,
    input  logic        l0_br,
    input  logic [6:0]  l0_exc,
    input  logic [6:0]  l1_exc,
    input  logic [31:0] l0_vaddr,
    input  logic [31:0] l1_vaddr,
    input  logic        l0_eret,
    input  logic        l1_eret,
    input  logic        int_pending,
    input  logic [31:0] cp0_epc,
    output logic        exc_valid,
    output logic [6:0]  exc_type,
    output logic [31:0] exc_pc,
    output logic [31:0] exc_vaddr,
    output logic        exc_slot,
    output logic        int_valid,
    output logic        eret_out,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [31:0] ExcVector = 32'hBFC0_0380;

    typedef enum logic [1:0] {StIdle, StFlush, StLock} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lock_cnt_q, lock_cnt_d;
    logic        int_saved_q, int_saved_d;

    logic        exc_valid_q, exc_valid_d;
    logic [6:0]  exc_type_q, exc_type_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic [31:0] exc_vaddr_q, exc_vaddr_d;
    logic        exc_slot_q, exc_slot_d;
    logic        int_valid_q, int_valid_d;
    logic        eret_q, eret_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic int_req;
    logic int_att0, int_att1;
    logic l0_exc_hit, l0_eret_hit, l1_exc_hit, l1_eret_hit;

    // Event qualification; lane events only count for valid instructions.
    always_comb begin
        int_req     = int_pending | int_saved_q;
        int_att0    = l0_valid;
        // A delay slot cannot take an interrupt on its own: the branch would be lost.
        int_att1    = ~l0_valid & l1_valid & ~l1_slot;
        l0_exc_hit  = l0_valid & (|l0_exc);
        l0_eret_hit = l0_valid & l0_eret;
        l1_exc_hit  = l1_valid & (|l1_exc);
        l1_eret_hit = l1_valid & l1_eret;
    end

    // Next-state logic: event selection in idle, fixed flush/lock sequence otherwise.
    always_comb begin
        state_d          = state_q;
        lock_cnt_d       = lock_cnt_q;
        int_saved_d      = int_saved_q;
        exc_valid_d      = 1'b0;
        int_valid_d      = 1'b0;
        eret_d           = 1'b0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        exc_type_d       = exc_type_q;
        exc_pc_d         = exc_pc_q;
        exc_vaddr_d      = exc_vaddr_q;
        exc_slot_d       = exc_slot_q;
        redirect_pc_d    = redirect_pc_q;

        unique case (state_q)
            StIdle: begin
                if (!stall) begin
                    if (int_req && (int_att0 || int_att1)) begin
                        exc_valid_d   = 1'b1;
                        int_valid_d   = 1'b1;
                        exc_type_d    = 7'd0;
                        exc_vaddr_d   = 32'd0;
                        redirect_pc_d = ExcVector;
                        int_saved_d   = 1'b0;
                        if (int_att0) begin
                            // On a branch, let it commit and restart at its delay slot.
                            exc_pc_d   = l0_br ? (l0_pc + 32'd4) : l0_pc;
                            exc_slot_d = l0_br ? 1'b0 : l0_slot;
                        end else begin
                            exc_pc_d   = l1_pc;
                            exc_slot_d = l1_slot;
                        end
                    end else begin
                        if (int_req) begin
                            int_saved_d = 1'b1;
                        end
                        if (l0_exc_hit) begin
                            exc_valid_d   = 1'b1;
                            exc_type_d    = l0_exc;
                            exc_pc_d      = l0_pc;
                            exc_vaddr_d   = l0_vaddr;
                            exc_slot_d    = l0_slot;
                            redirect_pc_d = ExcVector;
                        end else if (l0_eret_hit) begin
                            eret_d        = 1'b1;
                            redirect_pc_d = cp0_epc;
                        end else if (l1_exc_hit) begin
                            exc_valid_d   = 1'b1;
                            exc_type_d    = l1_exc;
                            exc_pc_d      = l1_pc;
                            exc_vaddr_d   = l1_vaddr;
                            exc_slot_d    = l1_slot;
                            redirect_pc_d = ExcVector;
                        end else if (l1_eret_hit) begin
                            eret_d        = 1'b1;
                            redirect_pc_d = cp0_epc;
                        end
                    end
                    if (exc_valid_d || eret_d) begin
                        flush_d          = 1'b1;
                        redirect_valid_d = 1'b1;
                        state_d          = StFlush;
                    end
                end
            end
            StFlush: begin
                if (int_pending) begin
                    int_saved_d = 1'b1;
                end
                state_d    = StLock;
                lock_cnt_d = 2'd2;
            end
            StLock: begin
                if (int_pending) begin
                    int_saved_d = 1'b1;
                end
                if (lock_cnt_q <= 2'd1) begin
                    state_d    = StIdle;
                    lock_cnt_d = 2'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                lock_cnt_d = 2'd0;
            end
        endcase
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            lock_cnt_q       <= 2'd0;
            int_saved_q      <= 1'b0;
            exc_valid_q      <= 1'b0;
            exc_type_q       <= 7'd0;
            exc_pc_q         <= 32'd0;
            exc_vaddr_q      <= 32'd0;
            exc_slot_q       <= 1'b0;
            int_valid_q      <= 1'b0;
            eret_q           <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            lock_cnt_q       <= lock_cnt_d;
            int_saved_q      <= int_saved_d;
            exc_valid_q      <= exc_valid_d;
            exc_type_q       <= exc_type_d;
            exc_pc_q         <= exc_pc_d;
            exc_vaddr_q      <= exc_vaddr_d;
            exc_slot_q       <= exc_slot_d;
            int_valid_q      <= int_valid_d;
            eret_q           <= eret_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign exc_valid      = exc_valid_q;
    assign exc_type       = exc_type_q;
    assign exc_pc         = exc_pc_q;
    assign exc_vaddr      = exc_vaddr_q;
    assign exc_slot       = exc_slot_q;
    assign int_valid      = int_valid_q;
    assign eret_out       = eret_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
